// File: rtl/train_state.sv
// Shared-segment arbiter for a two-loop layout: synchronizes four track
// sensors and drives turnouts plus per-train direction/speed commands.
module train_state #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       Clock,
   input  logic       RESET,
   input  logic [4:1] SR,
   output logic [3:1] SW,
   output logic [1:0] DA,
   output logic [1:0] DB
);

   typedef enum logic [2:0] {
      ABOUT     = 3'd0,
      AIN       = 3'd1,
      AIN_BSTOP = 3'd2,
      BIN       = 3'd3,
      BIN_ASTOP = 3'd4
   } state_t;

   localparam logic [1:0] CMD_STOP = 2'b00;
   localparam logic [1:0] CMD_FWD  = 2'b01;

   logic [4:1] r_sync [SYNC_STAGES];
   state_t     r_state;
   state_t     w_next;
   logic [4:1] w_s;

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge Clock) begin
      if (RESET) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            r_sync[i] <= '0;
         r_state <= ABOUT;
      end else begin
         r_sync[0] <= SR;
         for (int i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
         r_state <= w_next;
      end
   end

   // Branch order encodes priority; A wins a simultaneous request.
   always_comb begin
      w_next = ABOUT;
      case (r_state)
         ABOUT: begin
            if (w_s[1] && w_s[2]) w_next = AIN_BSTOP;
            else if (w_s[1])      w_next = AIN;
            else if (w_s[2])      w_next = BIN;
            else                  w_next = ABOUT;
         end
         AIN: begin
            if (w_s[3] && w_s[2]) w_next = BIN;
            else if (w_s[3])      w_next = ABOUT;
            else if (w_s[2])      w_next = AIN_BSTOP;
            else                  w_next = AIN;
         end
         AIN_BSTOP: begin
            if (w_s[3]) w_next = BIN;
            else        w_next = AIN_BSTOP;
         end
         BIN: begin
            if (w_s[4] && w_s[1]) w_next = AIN;
            else if (w_s[4])      w_next = ABOUT;
            else if (w_s[1])      w_next = BIN_ASTOP;
            else                  w_next = BIN;
         end
         BIN_ASTOP: begin
            if (w_s[4]) w_next = AIN;
            else        w_next = BIN_ASTOP;
         end
         default: w_next = ABOUT;
      endcase
   end

   always_comb begin
      SW = 3'b000;
      DA = CMD_STOP;
      DB = CMD_STOP;
      case (r_state)
         ABOUT: begin
            SW = 3'b000; DA = CMD_FWD; DB = CMD_FWD;
         end
         AIN: begin
            SW = 3'b001; DA = CMD_FWD; DB = CMD_FWD;
         end
         AIN_BSTOP: begin
            SW = 3'b001; DA = CMD_FWD; DB = CMD_STOP;
         end
         BIN: begin
            SW = 3'b110; DA = CMD_FWD; DB = CMD_FWD;
         end
         BIN_ASTOP: begin
            SW = 3'b110; DA = CMD_STOP; DB = CMD_FWD;
         end
         default: begin
            SW = 3'b000; DA = CMD_STOP; DB = CMD_STOP;
         end
      endcase
   end

endmodule

// File: tb/tb_train_state.sv
// Scoreboard bench for train_state: expected outputs queued at stimulus
// time, popped once the sensor-to-output latency has elapsed.
module tb_train_state;

   localparam int SS = 2;

   localparam logic [6:0] E_ABOUT = {3'b000, 2'b01, 2'b01};
   localparam logic [6:0] E_AIN   = {3'b001, 2'b01, 2'b01};
   localparam logic [6:0] E_AINBS = {3'b001, 2'b01, 2'b00};
   localparam logic [6:0] E_BIN   = {3'b110, 2'b01, 2'b01};
   localparam logic [6:0] E_BINAS = {3'b110, 2'b00, 2'b01};

   logic       Clock = 1'b0;
   logic       RESET = 1'b1;
   logic [4:1] SR    = 4'b0000;
   logic [3:1] SW;
   logic [1:0] DA;
   logic [1:0] DB;

   int n_chk  = 0;
   int n_fail = 0;

   logic [6:0] sb [$];
   logic [6:0] cur;
   logic [6:0] w_outs;

   assign w_outs = {SW, DA, DB};

   train_state #(.SYNC_STAGES(SS)) dut (
      .Clock (Clock),
      .RESET (RESET),
      .SR    (SR),
      .SW    (SW),
      .DA    (DA),
      .DB    (DB)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag,
                        input logic [6:0] got,
                        input logic [6:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got SW/DA/DB=%b required=%b", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(posedge Clock);
      #1;
   endtask

   task automatic safety(input string tag);
      check({tag, "_sw12"}, {6'b0, SW[1] & SW[2]}, 7'b0);
   endtask

   // Outputs must hold for SS edges, then show the new state on the next.
   task automatic apply(input logic [4:1] sr,
                        input logic [6:0] exp,
                        input string tag);
      logic [6:0] e;
      SR = sr;
      sb.push_back(exp);
      tick(SS);
      check({tag, "_hold"}, w_outs, cur);
      tick(1);
      if (sb.size() == 0) begin
         check({tag, "_sbempty"}, 7'h7f, 7'h00);
      end else begin
         e = sb.pop_front();
         check(tag, w_outs, e);
         cur = e;
      end
      safety(tag);
   endtask

   initial begin
      RESET = 1'b1;
      SR    = 4'b0000;
      tick(1);
      check("rst_edge1", w_outs, E_ABOUT);
      tick(1);
      check("rst_edge2", w_outs, E_ABOUT);
      RESET = 1'b0;
      tick(3);
      check("rst_idle", w_outs, E_ABOUT);
      cur = E_ABOUT;

      apply(4'b0001, E_AIN,   "a_enter");
      apply(4'b1001, E_AIN,   "a_ign_s4");
      apply(4'b0100, E_ABOUT, "a_clear");

      apply(4'b0001, E_AIN,   "c_a_enter");
      apply(4'b0010, E_AINBS, "c_b_held");
      apply(4'b0100, E_BIN,   "c_handoff");
      apply(4'b1000, E_ABOUT, "c_b_clear");

      apply(4'b0011, E_AINBS, "sim_req");
      apply(4'b0100, E_BIN,   "sim_handoff");
      apply(4'b1000, E_ABOUT, "sim_clear");

      apply(4'b0010, E_BIN,   "b_enter");
      apply(4'b0101, E_BINAS, "b_a_held");
      apply(4'b1000, E_AIN,   "b_handoff");
      apply(4'b0100, E_ABOUT, "b_a_clear");

      apply(4'b0001, E_AIN,   "d_a_enter");
      apply(4'b0110, E_BIN,   "d_direct");
      apply(4'b1001, E_AIN,   "d_back");
      apply(4'b0100, E_ABOUT, "d_clear");

      apply(4'b0010, E_BIN,   "r_b_enter");
      apply(4'b0001, E_BINAS, "r_a_held");
      RESET = 1'b1;
      tick(1);
      check("r_reset", w_outs, E_ABOUT);
      RESET = 1'b0;
      cur = E_ABOUT;
      apply(4'b0001, E_AIN,   "r_after");

      if (sb.size() != 0)
         check("sb_drain", 7'(sb.size()), 7'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
